// File: rtl/exe_pkg.sv
// Shared constants and register layouts for the execute stage.
package exe_pkg;

   localparam int REG_FILE_SIZE     = 32;
   localparam int REG_FILE_ADDR_LEN = 5;
   localparam int EXE_CMD_LEN       = 4;

   localparam logic [EXE_CMD_LEN-1:0] EXE_NOP = EXE_CMD_LEN'(0);
   localparam logic [EXE_CMD_LEN-1:0] EXE_ADD = EXE_CMD_LEN'(1);
   localparam logic [EXE_CMD_LEN-1:0] EXE_SUB = EXE_CMD_LEN'(2);
   localparam logic [EXE_CMD_LEN-1:0] EXE_AND = EXE_CMD_LEN'(3);
   localparam logic [EXE_CMD_LEN-1:0] EXE_OR  = EXE_CMD_LEN'(4);
   localparam logic [EXE_CMD_LEN-1:0] EXE_XOR = EXE_CMD_LEN'(5);
   localparam logic [EXE_CMD_LEN-1:0] EXE_SLL = EXE_CMD_LEN'(6);
   localparam logic [EXE_CMD_LEN-1:0] EXE_SRL = EXE_CMD_LEN'(7);
   localparam logic [EXE_CMD_LEN-1:0] EXE_MUL = EXE_CMD_LEN'(8);

   typedef enum logic [1:0] {IDLE, BUSY, DONE} mul_state_t;

   typedef struct packed {
      logic                         wb_en;
      logic                         mem_r_en;
      logic                         mem_w_en;
      logic                         is_imm;
      logic [EXE_CMD_LEN-1:0]       exe_cmd;
      logic [REG_FILE_ADDR_LEN-1:0] src1;
      logic [REG_FILE_ADDR_LEN-1:0] src2;
      logic [REG_FILE_ADDR_LEN-1:0] dest;
      logic [REG_FILE_SIZE-1:0]     val1;
      logic [REG_FILE_SIZE-1:0]     val2;
      logic [REG_FILE_SIZE-1:0]     imm;
   } id_exe_t;

   typedef struct packed {
      logic                         wb_en;
      logic                         mem_r_en;
      logic                         mem_w_en;
      logic [REG_FILE_ADDR_LEN-1:0] dest;
      logic [REG_FILE_SIZE-1:0]     alu_res;
      logic [REG_FILE_SIZE-1:0]     st_val;
   } exe_mem_t;

   // The youngest producer (EXE/MEM) wins over WB; register 0 is never bypassed.
   function automatic logic [REG_FILE_SIZE-1:0] fwd_sel(
      input logic                         en,
      input logic [REG_FILE_ADDR_LEN-1:0] src,
      input logic [REG_FILE_SIZE-1:0]     id_val,
      input logic                         mem_wb,
      input logic [REG_FILE_ADDR_LEN-1:0] mem_dest,
      input logic [REG_FILE_SIZE-1:0]     mem_val,
      input logic                         wb_wb,
      input logic [REG_FILE_ADDR_LEN-1:0] wb_dest,
      input logic [REG_FILE_SIZE-1:0]     wb_val);
      if (en && src != '0 && mem_wb && mem_dest == src) return mem_val;
      if (en && src != '0 && wb_wb && wb_dest == src) return wb_val;
      return id_val;
   endfunction

endpackage

// File: rtl/exe_mul_seq.sv
// Iterative shift-add multiplier: one bit of B per cycle, stalls the front end while busy.
module exe_mul_seq
   import exe_pkg::*;
#(
   parameter int DATA_W = REG_FILE_SIZE
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              start,
   input  logic [DATA_W-1:0] a,
   input  logic [DATA_W-1:0] b,
   output logic              stall,
   output logic              done,
   output logic [DATA_W-1:0] product
);

   localparam int CNT_W = $clog2(DATA_W);

   mul_state_t        state_reg;
   logic [CNT_W-1:0]  cnt_reg;
   logic [DATA_W-1:0] a_reg;
   logic [DATA_W-1:0] b_reg;
   logic [DATA_W-1:0] acc_reg;

   always_ff @(posedge clk) begin
      if (!rst) begin
         state_reg <= IDLE;
         cnt_reg   <= '0;
         a_reg     <= '0;
         b_reg     <= '0;
         acc_reg   <= '0;
      end else begin
         case (state_reg)
            IDLE: begin
               if (start) begin
                  a_reg     <= a;
                  b_reg     <= b;
                  acc_reg   <= '0;
                  cnt_reg   <= '0;
                  state_reg <= BUSY;
               end
            end
            BUSY: begin
               if (b_reg[0]) acc_reg <= acc_reg + a_reg;
               a_reg   <= a_reg << 1;
               b_reg   <= b_reg >> 1;
               cnt_reg <= cnt_reg + 1'b1;
               if (cnt_reg == CNT_W'(DATA_W - 1)) state_reg <= DONE;
            end
            DONE:    state_reg <= IDLE;
            default: state_reg <= IDLE;
         endcase
      end
   end

   // IDLE-with-MUL plus DATA_W BUSY cycles gives DATA_W+1 stall cycles.
   assign stall   = (state_reg == IDLE && start) || state_reg == BUSY;
   assign done    = state_reg == DONE;
   assign product = acc_reg;

endmodule

// File: rtl/exe_stage_mc.sv
// Execute stage: ID/EXE register, operand bypass, ALU, sequential multiplier, EXE/MEM register.
module exe_stage_mc
   import exe_pkg::*;
#(
   parameter int DATA_W = REG_FILE_SIZE,
   parameter int ADDR_W = REG_FILE_ADDR_LEN,
   parameter int CMD_W  = EXE_CMD_LEN
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              forward_EN,
   input  logic              hazard_detected,
   input  logic              is_imm,
   input  logic              ST,
   input  logic              MEM_R_EN,
   input  logic              MEM_W_EN,
   input  logic              WB_EN,
   input  logic [CMD_W-1:0]  EXE_CMD,
   input  logic [ADDR_W-1:0] src1,
   input  logic [ADDR_W-1:0] src2,
   input  logic [ADDR_W-1:0] dest,
   input  logic [DATA_W-1:0] val1,
   input  logic [DATA_W-1:0] val2,
   input  logic [DATA_W-1:0] imm,
   input  logic              WB_EN_WB,
   input  logic [ADDR_W-1:0] dest_WB,
   input  logic [DATA_W-1:0] writeVal,
   output logic              stall,
   output logic [DATA_W-1:0] alu_res,
   output logic [DATA_W-1:0] st_val,
   output logic [ADDR_W-1:0] dest_out,
   output logic              WB_EN_out,
   output logic              MEM_R_EN_out,
   output logic              MEM_W_EN_out
);

   id_exe_t           id_exe_reg;
   id_exe_t           id_exe_next;
   exe_mem_t          exe_mem_reg;
   exe_mem_t          exe_mem_next;
   logic [DATA_W-1:0] op_a;
   logic [DATA_W-1:0] fwd_b;
   logic [DATA_W-1:0] op_b;
   logic [DATA_W-1:0] alu_out;
   logic [DATA_W-1:0] product;
   logic              mul_done;
   logic              is_mul;

   // Store-ness is already carried by MEM_W_EN downstream.
   logic unused_ok;
   assign unused_ok = ST;

   always_comb begin
      id_exe_next          = '0;
      id_exe_next.wb_en    = WB_EN;
      id_exe_next.mem_r_en = MEM_R_EN;
      id_exe_next.mem_w_en = MEM_W_EN;
      id_exe_next.is_imm   = is_imm;
      id_exe_next.exe_cmd  = EXE_CMD;
      id_exe_next.src1     = src1;
      id_exe_next.src2     = src2;
      id_exe_next.dest     = dest;
      id_exe_next.val1     = val1;
      id_exe_next.val2     = val2;
      id_exe_next.imm      = imm;
   end

   // A stall outranks the hazard bubble, so a hazard during a multiply is ignored.
   always_ff @(posedge clk) begin
      if (!rst) begin
         id_exe_reg <= '0;
      end else if (!stall) begin
         id_exe_reg <= hazard_detected ? id_exe_t'('0) : id_exe_next;
      end
   end

   always_comb begin
      op_a  = fwd_sel(forward_EN, id_exe_reg.src1, id_exe_reg.val1,
                      exe_mem_reg.wb_en, exe_mem_reg.dest, exe_mem_reg.alu_res,
                      WB_EN_WB, dest_WB, writeVal);
      fwd_b = fwd_sel(forward_EN, id_exe_reg.src2, id_exe_reg.val2,
                      exe_mem_reg.wb_en, exe_mem_reg.dest, exe_mem_reg.alu_res,
                      WB_EN_WB, dest_WB, writeVal);
      op_b  = id_exe_reg.is_imm ? id_exe_reg.imm : fwd_b;
   end

   always_comb begin
      case (id_exe_reg.exe_cmd)
         EXE_ADD: alu_out = op_a + op_b;
         EXE_SUB: alu_out = op_a - op_b;
         EXE_AND: alu_out = op_a & op_b;
         EXE_OR:  alu_out = op_a | op_b;
         EXE_XOR: alu_out = op_a ^ op_b;
         EXE_SLL: alu_out = op_a << op_b[4:0];
         EXE_SRL: alu_out = op_a >> op_b[4:0];
         default: alu_out = '0;
      endcase
   end

   assign is_mul = id_exe_reg.exe_cmd == EXE_MUL;

   exe_mul_seq #(.DATA_W(DATA_W)) u_mul (
      .clk     (clk),
      .rst     (rst),
      .start   (is_mul),
      .a       (op_a),
      .b       (op_b),
      .stall   (stall),
      .done    (mul_done),
      .product (product)
   );

   always_comb begin
      exe_mem_next = '0;
      if (!is_mul || mul_done) begin
         exe_mem_next.wb_en    = id_exe_reg.wb_en;
         exe_mem_next.mem_r_en = id_exe_reg.mem_r_en;
         exe_mem_next.mem_w_en = id_exe_reg.mem_w_en;
         exe_mem_next.dest     = id_exe_reg.dest;
         exe_mem_next.alu_res  = is_mul ? product : alu_out;
         exe_mem_next.st_val   = fwd_b;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst) exe_mem_reg <= '0;
      else      exe_mem_reg <= exe_mem_next;
   end

   assign alu_res      = exe_mem_reg.alu_res;
   assign st_val       = exe_mem_reg.st_val;
   assign dest_out     = exe_mem_reg.dest;
   assign WB_EN_out    = exe_mem_reg.wb_en;
   assign MEM_R_EN_out = exe_mem_reg.mem_r_en;
   assign MEM_W_EN_out = exe_mem_reg.mem_w_en;

endmodule

// File: tb/tb_exe_stage_mc.sv
// Directed bench for exe_stage_mc: vector table plus multiply/reset sequences.
module tb_exe_stage_mc;
   import exe_pkg::*;

   logic        clk = 1'b0;
   logic        rst;
   logic        forward_EN, hazard_detected, is_imm, ST;
   logic        MEM_R_EN, MEM_W_EN, WB_EN;
   logic [3:0]  EXE_CMD;
   logic [4:0]  src1, src2, dest;
   logic [31:0] val1, val2, imm;
   logic        WB_EN_WB;
   logic [4:0]  dest_WB;
   logic [31:0] writeVal;
   logic        stall;
   logic [31:0] alu_res, st_val;
   logic [4:0]  dest_out;
   logic        WB_EN_out, MEM_R_EN_out, MEM_W_EN_out;

   always #5 clk = ~clk;

   exe_stage_mc dut (
      .clk(clk), .rst(rst), .forward_EN(forward_EN), .hazard_detected(hazard_detected),
      .is_imm(is_imm), .ST(ST), .MEM_R_EN(MEM_R_EN), .MEM_W_EN(MEM_W_EN), .WB_EN(WB_EN),
      .EXE_CMD(EXE_CMD), .src1(src1), .src2(src2), .dest(dest), .val1(val1), .val2(val2),
      .imm(imm), .WB_EN_WB(WB_EN_WB), .dest_WB(dest_WB), .writeVal(writeVal),
      .stall(stall), .alu_res(alu_res), .st_val(st_val), .dest_out(dest_out),
      .WB_EN_out(WB_EN_out), .MEM_R_EN_out(MEM_R_EN_out), .MEM_W_EN_out(MEM_W_EN_out)
   );

   typedef struct {
      logic [3:0]  cmd;
      logic [4:0]  s1, s2, d;
      logic [31:0] v1, v2, im;
      logic        isi, wb, mr, mw, hz, fw, wbwb;
      logic [4:0]  dwb;
      logic [31:0] wv;
      logic [31:0] e_res, e_st;
      logic [4:0]  e_dest;
      logic        e_wb, e_mr, e_mw;
   } vec_t;

   vec_t vecs[$];
   int   checks = 0;
   int   errors = 0;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
      end
   endtask

   task automatic add_vec(input logic [3:0] cmd, input logic [4:0] s1, input logic [4:0] s2,
                          input logic [4:0] d, input logic [31:0] v1, input logic [31:0] v2,
                          input logic [31:0] im, input logic isi, input logic wb, input logic mr,
                          input logic mw, input logic hz, input logic fw, input logic wbwb,
                          input logic [4:0] dwb, input logic [31:0] wv, input logic [31:0] e_res,
                          input logic [31:0] e_st, input logic [4:0] e_dest, input logic e_wb,
                          input logic e_mr, input logic e_mw);
      vec_t v;
      v.cmd = cmd; v.s1 = s1; v.s2 = s2; v.d = d; v.v1 = v1; v.v2 = v2; v.im = im;
      v.isi = isi; v.wb = wb; v.mr = mr; v.mw = mw; v.hz = hz; v.fw = fw; v.wbwb = wbwb;
      v.dwb = dwb; v.wv = wv; v.e_res = e_res; v.e_st = e_st; v.e_dest = e_dest;
      v.e_wb = e_wb; v.e_mr = e_mr; v.e_mw = e_mw;
      vecs.push_back(v);
   endtask

   task automatic drive_id(input logic [3:0] cmd, input logic [4:0] d, input logic [31:0] v1,
                           input logic [31:0] v2, input logic wb);
      EXE_CMD = cmd; dest = d; val1 = v1; val2 = v2; WB_EN = wb;
      src1 = '0; src2 = '0; imm = '0; is_imm = 1'b0; ST = 1'b0;
      MEM_R_EN = 1'b0; MEM_W_EN = 1'b0; hazard_detected = 1'b0;
   endtask

   task automatic drive_vec_id(input vec_t v);
      EXE_CMD = v.cmd; src1 = v.s1; src2 = v.s2; dest = v.d; val1 = v.v1; val2 = v.v2;
      imm = v.im; is_imm = v.isi; WB_EN = v.wb; MEM_R_EN = v.mr; MEM_W_EN = v.mw;
      ST = v.mw; hazard_detected = v.hz;
   endtask

   task automatic drive_vec_fwd(input vec_t v);
      forward_EN = v.fw; WB_EN_WB = v.wbwb; dest_WB = v.dwb; writeVal = v.wv;
   endtask

   task automatic clear_fwd();
      forward_EN = 1'b1; WB_EN_WB = 1'b0; dest_WB = '0; writeVal = '0;
   endtask

   task automatic count_stall(output int cnt);
      cnt = 0;
      while (stall === 1'b1 && cnt < 100) begin
         cnt++;
         @(negedge clk);
      end
   endtask

   task automatic chk_out(input string nm, input logic [31:0] res, input logic [4:0] d,
                          input logic wb);
      $display("txn %s: alu_res=%0h dest_out=%0d WB_EN_out=%0b", nm, alu_res, dest_out, WB_EN_out);
      chk({nm, "_res"}, alu_res, res);
      chk({nm, "_dest"}, {27'd0, dest_out}, {27'd0, d});
      chk({nm, "_wb"}, {31'd0, WB_EN_out}, {31'd0, wb});
   endtask

   initial begin
      #200000;
      $display("FAIL timeout alu_res=%0h required=finish", alu_res);
      $fatal(1);
   end

   initial begin
      int   n;
      logic saw42;
      vec_t v;

      // Vector table: ID fields are captured at one edge; forward/WB fields apply the cycle after.
      //       cmd      s1 s2 d  v1            v2            imm        isi wb mr mw hz fw wbwb dwb wv     e_res         e_st       ed e_wb e_mr e_mw
      add_vec(EXE_ADD, 0, 0, 4, 32'd5,        32'd3,        32'd0,     0, 1, 0, 0, 0, 1, 0,   0,  32'd0, 32'd8,        32'd3,     4, 1, 0, 0);
      add_vec(EXE_ADD, 0, 0, 1, 32'd2,        32'd3,        32'd0,     0, 1, 0, 0, 0, 1, 0,   0,  32'd0, 32'd5,        32'd3,     1, 1, 0, 0);
      add_vec(EXE_SUB, 1, 0, 5, 32'd0,        32'd1,        32'd0,     0, 1, 0, 0, 0, 1, 0,   0,  32'd0, 32'd4,        32'd1,     5, 1, 0, 0);
      add_vec(EXE_ADD, 0, 0, 1, 32'd2,        32'd3,        32'd0,     0, 1, 0, 0, 0, 1, 0,   0,  32'd0, 32'd5,        32'd3,     1, 1, 0, 0);
      add_vec(EXE_SUB, 1, 0, 6, 32'd0,        32'd1,        32'd0,     0, 1, 0, 0, 0, 0, 0,   0,  32'd0, 32'hFFFFFFFF, 32'd1,     6, 1, 0, 0);
      add_vec(EXE_SUB, 0, 2, 7, 32'd15,       32'd99,       32'd0,     0, 1, 0, 0, 0, 1, 1,   2,  32'd10, 32'd5,       32'd10,    7, 1, 0, 0);
      add_vec(EXE_SUB, 0, 0, 7, 32'd15,       32'd3,        32'd0,     0, 1, 0, 0, 0, 1, 1,   0,  32'd10, 32'd12,      32'd3,     7, 1, 0, 0);
      add_vec(EXE_ADD, 0, 0, 3, 32'd1,        32'd1,        32'd0,     0, 1, 0, 0, 0, 1, 0,   0,  32'd0, 32'd2,        32'd1,     3, 1, 0, 0);
      add_vec(EXE_OR,  3, 0, 8, 32'hFF,       32'hF0,       32'd0,     0, 1, 0, 0, 0, 1, 1,   3,  32'd7, 32'hF2,       32'hF0,    8, 1, 0, 0);
      add_vec(EXE_XOR, 0, 0, 8, 32'hF0F0,     32'h0FF0,     32'd0,     0, 1, 0, 0, 0, 1, 0,   0,  32'd0, 32'hFF00,     32'h0FF0,  8, 1, 0, 0);
      add_vec(EXE_SLL, 0, 0, 9, 32'd1,        32'h55,       32'h24,    1, 1, 0, 0, 0, 1, 0,   0,  32'd0, 32'd16,       32'h55,    9, 1, 0, 0);
      add_vec(EXE_SRL, 0, 0, 9, 32'h80000000, 32'd31,       32'd0,     0, 1, 0, 0, 0, 1, 0,   0,  32'd0, 32'd1,        32'd31,    9, 1, 0, 0);
      add_vec(EXE_AND, 0, 0, 9, 32'hF0F0,     32'hFF00,     32'd0,     0, 1, 0, 0, 0, 1, 0,   0,  32'd0, 32'hF000,     32'hFF00,  9, 1, 0, 0);
      add_vec(EXE_ADD, 0, 0, 4, 32'd5,        32'd3,        32'd0,     0, 1, 0, 1, 1, 1, 0,   0,  32'd0, 32'd0,        32'd0,     0, 0, 0, 0);
      add_vec(EXE_ADD, 0, 0, 0, 32'd100,      32'h1234,     32'd4,     1, 0, 0, 1, 0, 1, 0,   0,  32'd0, 32'd104,      32'h1234,  0, 0, 0, 1);
      add_vec(EXE_ADD, 0, 0, 9, 32'd8,        32'd0,        32'd8,     1, 1, 1, 0, 0, 1, 0,   0,  32'd0, 32'd16,       32'd0,     9, 1, 1, 0);
      add_vec(EXE_NOP, 0, 0, 2, 32'd5,        32'd6,        32'd0,     0, 1, 0, 0, 0, 1, 0,   0,  32'd0, 32'd0,        32'd6,     2, 1, 0, 0);

      // Reset with a live instruction on the inputs: everything must read zero.
      rst = 1'b0;
      clear_fwd();
      drive_id(EXE_ADD, 5'd4, 32'd5, 32'd3, 1'b1);
      repeat (3) @(posedge clk);
      @(negedge clk);
      chk_out("reset", 32'd0, 5'd0, 1'b0);
      chk("reset_st_val", st_val, 32'd0);
      chk("reset_mem_r", {31'd0, MEM_R_EN_out}, 32'd0);
      chk("reset_mem_w", {31'd0, MEM_W_EN_out}, 32'd0);
      chk("reset_stall", {31'd0, stall}, 32'd0);
      rst = 1'b1;
      drive_id(EXE_NOP, 5'd0, 32'd0, 32'd0, 1'b0);
      @(negedge clk);

      for (int k = 0; k < vecs.size() + 2; k++) begin
         @(negedge clk);
         if (k >= 2) begin
            v = vecs[k-2];
            $display("txn vec%0d: alu_res=%0h st_val=%0h dest_out=%0d", k - 2, alu_res, st_val, dest_out);
            chk($sformatf("vec%0d_res", k - 2), alu_res, v.e_res);
            chk($sformatf("vec%0d_st", k - 2), st_val, v.e_st);
            chk($sformatf("vec%0d_dest", k - 2), {27'd0, dest_out}, {27'd0, v.e_dest});
            chk($sformatf("vec%0d_ctl", k - 2), {29'd0, WB_EN_out, MEM_R_EN_out, MEM_W_EN_out},
                {29'd0, v.e_wb, v.e_mr, v.e_mw});
         end
         if (k < vecs.size()) drive_vec_id(vecs[k]);
         else drive_id(EXE_NOP, 5'd0, 32'd0, 32'd0, 1'b0);
         if (k >= 1 && k - 1 < vecs.size()) drive_vec_fwd(vecs[k-1]);
         else clear_fwd();
      end
      clear_fwd();

      // Single multiply with a dependent-free ADD waiting behind it.
      @(negedge clk);
      drive_id(EXE_MUL, 5'd10, 32'd7, 32'd6, 1'b1);
      @(negedge clk);
      drive_id(EXE_ADD, 5'd11, 32'd1, 32'd2, 1'b1);
      count_stall(n);
      chk("mul_stall_cycles", n, 32'd33);
      chk_out("mul_bubble", 32'd0, 5'd0, 1'b0);
      @(negedge clk);
      chk_out("mul_result", 32'd42, 5'd10, 1'b1);
      chk("mul_stall_after", {31'd0, stall}, 32'd0);
      drive_id(EXE_NOP, 5'd0, 32'd0, 32'd0, 1'b0);
      @(negedge clk);
      chk_out("mul_next_add", 32'd3, 5'd11, 1'b1);

      // Back-to-back multiplies followed by an ADD.
      @(negedge clk);
      drive_id(EXE_MUL, 5'd12, 32'd3, 32'd4, 1'b1);
      @(negedge clk);
      drive_id(EXE_MUL, 5'd13, 32'd5, 32'd5, 1'b1);
      count_stall(n);
      chk("b2b_stall1", n, 32'd33);
      @(negedge clk);
      chk_out("b2b_mul1", 32'd12, 5'd12, 1'b1);
      chk("b2b_idle_stall", {31'd0, stall}, 32'd1);
      drive_id(EXE_ADD, 5'd14, 32'd10, 32'd20, 1'b1);
      count_stall(n);
      chk("b2b_stall2", n, 32'd33);
      @(negedge clk);
      chk_out("b2b_mul2", 32'd25, 5'd13, 1'b1);
      drive_id(EXE_NOP, 5'd0, 32'd0, 32'd0, 1'b0);
      @(negedge clk);
      chk_out("b2b_add", 32'd30, 5'd14, 1'b1);

      // Reset in the 10th BUSY cycle discards the multiply.
      @(negedge clk);
      drive_id(EXE_MUL, 5'd10, 32'd7, 32'd6, 1'b1);
      @(negedge clk);
      drive_id(EXE_NOP, 5'd0, 32'd0, 32'd0, 1'b0);
      repeat (10) @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      chk_out("rst_mid_mul", 32'd0, 5'd0, 1'b0);
      chk("rst_mid_stall", {31'd0, stall}, 32'd0);
      chk("rst_mid_st_val", st_val, 32'd0);
      rst = 1'b1;
      saw42 = 1'b0;
      repeat (45) begin
         @(negedge clk);
         if (alu_res == 32'd42) saw42 = 1'b1;
      end
      chk("rst_no_42", {31'd0, saw42}, 32'd0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
